fft_reorder_out: RTL
====================

Name: fft_reorder_out

Overview:
- Output reorder buffer at the far end of the N=128, 2-lane parallel FFT pipeline, after the last quantiser.
- Accepts the FFT output stream in bit-reversed bin order on two lanes.
- Emits the same frame in natural bin order on two lanes.
- Ping-pong register banks: one frame is written while the previous one is read, so the output streams without stalls.

Parameters:
- NBITS, 15, width of one real or imaginary component; a sample is {re,im}, 2*NBITS bits, re in the MSBs.
- N, 128, FFT points per frame; must be a power of 2, ≥4.
- LOGN, $clog2(N), index width; derived, never overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fftIn0  in  2*NBITS  lane-0 sample, bit-reversed order.
- fftIn1  in  2*NBITS  lane-1 sample, bit-reversed order.
- in_valid  in  1  lane samples valid this cycle.
- in_sof  in  1  first sample pair of a frame; qualified by in_valid.
- fftOut0  out  2*NBITS  lane-0 sample, natural order.
- fftOut1  out  2*NBITS  lane-1 sample, natural order.
- out_valid  out  1  output samples valid.
- out_sof  out  1  first output pair of a frame.
- busy  out  1  a frame is partially written or being read.

Behaviour:
- Frame geometry: N/2 valid input cycles per frame. Write index w runs 0..N/2-1.
- Input mapping at write index w: fftIn0 carries bin bitrev(2w), fftIn1 carries bin bitrev(2w+1). bitrev is over LOGN bits.
- Output mapping at read index r (0..N/2-1): fftOut0 = bin 2r, fftOut1 = bin 2r+1.
- Storage: two banks of N words of 2*NBITS. Each bank holds at most one write pair and one read pair per cycle.
- Write side:
  - Each in_valid cycle stores both lanes into the write bank at the two bit-reversed addresses, then w increments.
  - in_valid low: w holds. Gaps of any length are allowed.
  - in_valid with in_sof forces the pair to w=0 and discards any partial frame in the write bank.
  - in_sof without in_valid is ignored.
- Frame complete: the write at w=N/2-1 completes the frame.
  - Next cycle: the banks swap, w=0, and the read side starts.
  - in_valid is accepted on the swap cycle, into the new write bank.
- Read side: FSM with states IDLE and READ.
  - IDLE→READ on frame complete; r=0.
  - READ: out_valid=1, with outputs registered from bank[2r] and bank[2r+1].
  - r increments every cycle. No backpressure; N/2 consecutive valid cycles.
  - out_sof=1 only at r=0.
  - After r=N/2-1: back to IDLE, unless another frame completed the same cycle; then continue into READ with r=0 and no bubble.
- Latency: first out_valid occurs 1 cycle after the cycle in which the last input pair of the frame is sampled.
- Overrun is impossible: a frame needs ≥N/2 cycles to fill and a read lasts exactly N/2. An assertion in the bench checks that frame complete never occurs while r<N/2-1.
- No arithmetic: samples pass bit-exact, with no sign extension or rounding.
- busy=1 when w≠0 or the FSM is in READ.
- Reset (rst=0, asynchronous):
  - w=0, r=0, FSM=IDLE, write bank = bank 0.
  - fftOut0=0, fftOut1=0, out_valid=0, out_sof=0, busy=0.
  - Bank contents are not reset.
  - Reset mid-read aborts the output immediately. Reset mid-write discards the partial frame.
- While out_valid=0, fftOut0 and fftOut1 hold their last value.

Test Plan:
- Single frame, in_valid continuous, each lane sample value = its bin index.
  - Input cycle 0 carries bins 0/64; cycle 1 carries bins 32/96.
  - Required: 1 cycle after input cycle 63, 64 valid cycles with fftOut0=2r and fftOut1=2r+1. out_sof only at r=0. busy drops after the last pair.
- Back-to-back frames, continuous input, frame f tagged in the MSBs.
  - Required: 192 consecutive out_valid cycles with no bubble between frames. out_sof at cycles 0, 64 and 128 of the output burst. Tags in order.
- Gapped input: in_valid toggling 1-0-0 random.
  - Required: natural-order output identical to the first scenario. out_valid starts 1 cycle after the 64th valid input.
- Resync: 20 valid pairs, then in_sof with in_valid, then 63 more pairs.
  - Required: only the frame beginning at the in_sof pair is output; the first 20 pairs never appear.
- Async reset during the read at r=10.
  - Required: out_valid, out_sof, busy and the outputs are 0 immediately.
  - After release, a fresh frame reorders correctly starting at r=0.
- Extreme values: re=0x4000 (−16384), im=0x3FFF on every bin.
  - Required: outputs bit-exact, with no width change.

Source files
------------

// File: rtl/fft_reorder_out.sv
// rtl/fft_reorder_out.sv - ping-pong reorder buffer, bit-reversed to natural order, 2 lanes
module fft_reorder_out #(
    parameter int  NBITS = 15,
    parameter int  N     = 128,
    localparam int LOGN  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*NBITS-1:0]   fftIn0,
    input  logic [2*NBITS-1:0]   fftIn1,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic [2*NBITS-1:0]   fftOut0,
    output logic [2*NBITS-1:0]   fftOut1,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 busy
);

    localparam int HALF = N / 2;
    localparam int WW   = LOGN - 1;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] y;
        for (int i = 0; i < LOGN; i++) begin
            y[i] = x[LOGN-1-i];
        end
        return y;
    endfunction

    // Frame storage; contents are never reset, a new frame overwrites every word.
    logic [2*NBITS-1:0] bank_q [2][N];

    logic [WW-1:0]      w_q, w_d;
    logic [WW-1:0]      r_q, r_d;
    logic               wr_bank_q, wr_bank_d;
    state_t             st_q, st_d;
    logic               sof_q, sof_d;
    logic [2*NBITS-1:0] out0_q, out0_d;
    logic [2*NBITS-1:0] out1_q, out1_d;

    logic [WW-1:0]      w_eff;
    logic [LOGN-1:0]    wa0, wa1;
    logic               frame_done;

    logic               rd_bank;
    logic [WW-1:0]      ra_pair;
    logic [LOGN-1:0]    ra0, ra1;
    logic [2*NBITS-1:0] rd0, rd1;

    // Write index: in_sof restarts the frame, the last pair of a frame swaps banks.
    always_comb begin
        w_eff      = in_sof ? '0 : w_q;
        wa0        = bitrev({w_eff, 1'b0});
        wa1        = bitrev({w_eff, 1'b1});
        frame_done = in_valid && (w_eff == WW'(HALF - 1));
        w_d        = w_q;
        wr_bank_d  = wr_bank_q;
        if (in_valid) begin
            w_d = frame_done ? '0 : w_eff + 1'b1;
        end
        if (frame_done) begin
            wr_bank_d = ~wr_bank_q;
        end
    end

    // Store both lanes at their bit-reversed addresses in the current write bank.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            bank_q[wr_bank_q][wa0] <= fftIn0;
            bank_q[wr_bank_q][wa1] <= fftIn1;
        end
    end

    // Read FSM and output register loading. Pair 0 is fetched on the completing
    // cycle itself, from the bank still being written, with the incoming pair
    // forwarded so the output appears one cycle after the last input.
    always_comb begin
        st_d    = st_q;
        r_d     = r_q;
        sof_d   = 1'b0;
        out0_d  = out0_q;
        out1_d  = out1_q;
        rd_bank = ~wr_bank_q;
        ra_pair = r_q + 1'b1;

        if (frame_done) begin
            rd_bank = wr_bank_q;
            ra_pair = '0;
        end

        ra0 = {ra_pair, 1'b0};
        ra1 = {ra_pair, 1'b1};
        rd0 = bank_q[rd_bank][ra0];
        rd1 = bank_q[rd_bank][ra1];
        if (frame_done) begin
            if (wa0 == ra0) begin
                rd0 = fftIn0;
            end else if (wa1 == ra0) begin
                rd0 = fftIn1;
            end
            if (wa0 == ra1) begin
                rd1 = fftIn0;
            end else if (wa1 == ra1) begin
                rd1 = fftIn1;
            end
        end

        if (frame_done) begin
            st_d   = READ;
            r_d    = '0;
            sof_d  = 1'b1;
            out0_d = rd0;
            out1_d = rd1;
        end else if (st_q == READ) begin
            if (r_q == WW'(HALF - 1)) begin
                st_d = IDLE;
                r_d  = '0;
            end else begin
                r_d    = r_q + 1'b1;
                out0_d = rd0;
                out1_d = rd1;
            end
        end
    end

    // State registers; reset aborts any read and discards a partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q       <= '0;
            r_q       <= '0;
            wr_bank_q <= 1'b0;
            st_q      <= IDLE;
            sof_q     <= 1'b0;
            out0_q    <= '0;
            out1_q    <= '0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            wr_bank_q <= wr_bank_d;
            st_q      <= st_d;
            sof_q     <= sof_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
        end
    end

    assign fftOut0   = out0_q;
    assign fftOut1   = out1_q;
    assign out_valid = (st_q == READ);
    assign out_sof   = sof_q;
    assign busy      = (w_q != '0) || (st_q == READ);

endmodule
